// File: rtl/fsqrt_iter.sv
// fsqrt_iter: iterative binary32 square root.
// A table seed for 1/sqrt(a) is refined by ITERS Newton steps through one
// shared datapath, then y = a*x is rounded to nearest-even.
// Build option: define FSQRT_SPECIAL_EN to detect zero, subnormal, inf and NaN
// operands and bypass the arithmetic. Without it only negative nonzero
// operands are caught.
module fsqrt_iter #(
   parameter int unsigned ITERS     = 2,
   parameter int unsigned SEED_BITS = 7
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data
);

   localparam int unsigned IT_W   = 2;
   localparam int unsigned FRAC_W = SEED_BITS + 1;
   localparam int unsigned IDX_W  = SEED_BITS + 1;
   localparam int unsigned SEED_N = 2 ** IDX_W;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_SEED  = 3'd1;
   localparam logic [2:0] S_ITER  = 3'd2;
   localparam logic [2:0] S_ROUND = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   // Largest x with x^2 * a_mid <= 1, x in FRAC_W fractional bits, placed in Q2.30.
   // Index MSB selects the odd-exponent half (a in [2,4)).
   function automatic logic [31:0] seed_fn(input int unsigned idx);
      logic [63:0] num;
      logic [63:0] rhs;
      logic [63:0] prod;
      int unsigned lo;
      int unsigned hi;
      int unsigned mid;
      num = (64'd1 << (SEED_BITS + 1)) + 64'(2 * (idx % (2 ** SEED_BITS))) + 64'd1;
      if (idx >= 2 ** SEED_BITS) num = num << 1;
      rhs = 64'd1 << (2 * FRAC_W + SEED_BITS + 1);
      lo  = 0;
      hi  = 2 ** FRAC_W;
      for (int i = 0; i <= int'(FRAC_W); i++) begin
         if (lo < hi) begin
            mid  = (lo + hi + 1) / 2;
            prod = 64'(mid) * 64'(mid) * num;
            if (prod <= rhs) lo = mid;
            else hi = mid - 1;
         end
      end
      return 32'(lo) << (30 - FRAC_W);
   endfunction

   logic [2:0]      r_state, w_state_nxt;
   logic [IT_W-1:0] r_it, w_it_nxt;
   logic [31:0]     r_op, w_op_nxt;
   logic [31:0]     r_a, w_a_nxt;
   logic [31:0]     r_x, w_x_nxt;
   logic [7:0]      r_exp, w_exp_nxt;
   logic            r_byp, w_byp_nxt;
   logic [31:0]     r_bval, w_bval_nxt;
   logic [31:0]     r_out, w_out_nxt;
   logic            r_ovalid, w_ovalid_nxt;
   logic            r_in_ready, w_in_ready_nxt;

   logic [31:0]     w_rom [0:SEED_N-1];

   // Seed ROM built at elaboration.
   for (genvar g = 0; g < int'(SEED_N); g++) begin : g_rom
      assign w_rom[g] = seed_fn(32'(g));
   end

   // Operand fields and seed-stage values.
   logic              w_sgn_in;
   logic [7:0]        w_exp_in;
   logic [22:0]       w_man_in;
   logic signed [9:0] w_u;
   logic [7:0]        w_rexp;
   logic              w_odd;
   logic [IDX_W-1:0]  w_idx;
   logic [31:0]       w_a0;
   logic              w_byp;
   logic [31:0]       w_bval;

   assign w_sgn_in = r_op[31];
   assign w_exp_in = r_op[30:23];
   assign w_man_in = r_op[22:0];
   assign w_u      = $signed({2'b00, w_exp_in}) - 10'sd127;
   assign w_rexp   = 8'((w_u >>> 1) + 10'sd127);
   assign w_odd    = w_u[0];
   assign w_idx    = {w_odd, w_man_in[22 -: SEED_BITS]};
   assign w_a0     = w_odd ? {1'b1, w_man_in, 8'd0} : {2'b01, w_man_in, 7'd0};

`ifdef FSQRT_SPECIAL_EN
   // Special-operand classification; NaN outranks the sign test.
   always_comb begin
      w_byp  = 1'b1;
      w_bval = 32'h7FC0_0000;
      if (w_exp_in == 8'hFF && w_man_in != 23'd0) w_bval = 32'h7FC0_0000;
      else if (w_exp_in == 8'h00)                 w_bval = {w_sgn_in, 31'd0};
      else if (w_sgn_in)                          w_bval = 32'h7FC0_0000;
      else if (w_exp_in == 8'hFF)                 w_bval = 32'h7F80_0000;
      else                                        w_byp  = 1'b0;
   end
`else
   assign w_byp  = w_sgn_in && (r_op[30:0] != 31'd0);
   assign w_bval = 32'h7F80_0001;
`endif

   // One Newton step: x * (3 - a*x^2) / 2, each product truncated to Q2.30.
   logic [63:0] w_xx_p, w_ax2_p, w_xt_p;
   logic [31:0] w_x2, w_ax2, w_t, w_xn;

   assign w_xx_p  = 64'(r_x) * 64'(r_x);
   assign w_x2    = 32'(w_xx_p >> 30);
   assign w_ax2_p = 64'(r_a) * 64'(w_x2);
   assign w_ax2   = 32'(w_ax2_p >> 30);
   assign w_t     = 32'hC000_0000 - w_ax2;
   assign w_xt_p  = 64'(r_x) * 64'(w_t);
   assign w_xn    = 32'(w_xt_p >> 31);

   // Rounding of y = a*x. y sits just below 1.0 only when it rounds up to
   // 1.0, so the exponent is pre-decremented and the mantissa carry restores it.
   logic [63:0] w_y_p;
   logic [22:0] w_mant_raw;
   logic [6:0]  w_grs;
   logic        w_hid;
   logic        w_inc;
   logic [30:0] w_res;

   assign w_y_p      = 64'(r_a) * 64'(r_x);
   assign w_mant_raw = 23'(w_y_p >> 37);
   assign w_grs      = 7'(w_y_p >> 30);
   assign w_hid      = w_y_p[60];
   assign w_inc      = w_grs[6] & (w_grs[5] | (|w_grs[4:0]) | w_mant_raw[0]);
   assign w_res      = {r_exp - {7'd0, ~w_hid}, w_mant_raw} + 31'(w_inc);

   // Next-state and next-output logic.
   always_comb begin
      w_state_nxt  = r_state;
      w_it_nxt     = r_it;
      w_op_nxt     = r_op;
      w_a_nxt      = r_a;
      w_x_nxt      = r_x;
      w_exp_nxt    = r_exp;
      w_byp_nxt    = r_byp;
      w_bval_nxt   = r_bval;
      w_out_nxt    = r_out;
      w_ovalid_nxt = r_ovalid;
      case (r_state)
         S_IDLE: begin
            if (in_valid) begin
               w_op_nxt    = in_data;
               w_state_nxt = S_SEED;
            end
         end
         S_SEED: begin
            w_exp_nxt  = w_rexp;
            w_byp_nxt  = w_byp;
            w_bval_nxt = w_bval;
            if (!w_byp) begin
               w_a_nxt = w_a0;
               w_x_nxt = w_rom[w_idx];
            end
            w_it_nxt    = '0;
            w_state_nxt = S_ITER;
         end
         S_ITER: begin
            if (!r_byp) w_x_nxt = w_xn;
            if (r_it == IT_W'(ITERS - 1)) begin
               w_it_nxt    = '0;
               w_state_nxt = S_ROUND;
            end else begin
               w_it_nxt = r_it + IT_W'(1);
            end
         end
         S_ROUND: begin
            w_out_nxt    = r_byp ? r_bval : {1'b0, w_res};
            w_ovalid_nxt = 1'b1;
            w_state_nxt  = S_DONE;
         end
         S_DONE: begin
            if (out_ready) begin
               w_ovalid_nxt = 1'b0;
               w_state_nxt  = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
      w_in_ready_nxt = (w_state_nxt == S_IDLE);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state    <= S_IDLE;
         r_it       <= '0;
         r_op       <= '0;
         r_a        <= '0;
         r_x        <= '0;
         r_exp      <= '0;
         r_byp      <= 1'b0;
         r_bval     <= '0;
         r_out      <= '0;
         r_ovalid   <= 1'b0;
         r_in_ready <= 1'b1;
      end else begin
         r_state    <= w_state_nxt;
         r_it       <= w_it_nxt;
         r_op       <= w_op_nxt;
         r_a        <= w_a_nxt;
         r_x        <= w_x_nxt;
         r_exp      <= w_exp_nxt;
         r_byp      <= w_byp_nxt;
         r_bval     <= w_bval_nxt;
         r_out      <= w_out_nxt;
         r_ovalid   <= w_ovalid_nxt;
         r_in_ready <= w_in_ready_nxt;
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_ovalid;
   assign out_data  = r_out;

endmodule

// File: tb/tb_fsqrt_iter.sv
// tb_fsqrt_iter: self-checking bench for fsqrt_iter against a real-arithmetic model.
module tb_fsqrt_iter;

   localparam int unsigned ITERS     = 2;
   localparam int unsigned SEED_BITS = 7;
   localparam int          LAT       = ITERS + 3;
   localparam int          PERIOD    = ITERS + 4;

   logic        clk = 1'b0;
   logic        rstn = 1'b1;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [31:0] in_data = 32'd0;
   logic        in_ready;
   logic        out_valid;
   logic [31:0] out_data;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   fsqrt_iter #(.ITERS(ITERS), .SEED_BITS(SEED_BITS)) dut (
      .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic real pow2(input int n);
      real v;
      v = 1.0;
      for (int i = 0; i < n; i++) v = v * 2.0;
      for (int i = 0; i < -n; i++) v = v / 2.0;
      return v;
   endfunction

   function automatic real f32_to_real(input logic [31:0] b);
      real m;
      m = (8388608.0 + real'(int'(b[22:0]))) / 8388608.0;
      return m * pow2(int'(b[30:23]) - 127);
   endfunction

   // Positive normal real -> binary32, round to nearest-even.
   function automatic logic [31:0] real_to_f32(input real v);
      real m;
      real f;
      real rem;
      int  e;
      int  q;
      m = v;
      e = 0;
      while (m >= 2.0) begin m = m / 2.0; e++; end
      while (m < 1.0)  begin m = m * 2.0; e--; end
      f   = m * 8388608.0;
      q   = $rtoi(f);
      rem = f - real'(q);
      if (rem > 0.5 || (rem == 0.5 && q[0])) q++;
      if (q == 16777216) begin q = 8388608; e++; end
      return {1'b0, 8'(e + 127), 23'(q)};
   endfunction

   task automatic run_op(input logic [31:0] d, output logic [31:0] res,
                         output int lat, output int t_acc, output bit to);
      int n;
      @(negedge clk);
      in_data   = d;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      n = 0;
      while (!in_ready && n < 50) begin @(negedge clk); n++; end
      t_acc = cyc;
      to    = !in_ready;
      @(negedge clk);
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 50) begin @(negedge clk); n++; end
      if (!out_valid) to = 1'b1;
      lat = cyc - t_acc;
      res = out_data;
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      repeat (2) @(negedge clk);
      n_tests++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_values: got rdy=%b vld=%b data=%h expected rdy=1 vld=0 data=00000000",
                  in_ready, out_valid, out_data);
      end
      rstn = 1'b1;
      @(negedge clk);
      n_tests++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release: got rdy=%b vld=%b expected rdy=1 vld=0", in_ready, out_valid);
      end
   endtask

   task automatic test_directed();
      logic [31:0] vin [5];
      logic [31:0] vexp [5];
      logic [31:0] res;
      int lat, t_acc;
      bit to;
      vin[0] = 32'h40800000; vexp[0] = 32'h40000000;
      vin[1] = 32'h40000000; vexp[1] = 32'h3FB504F3;
      vin[2] = 32'h3F000000; vexp[2] = 32'h3F3504F3;
      vin[3] = 32'h3E800000; vexp[3] = 32'h3F000000;
      vin[4] = 32'h41100000; vexp[4] = 32'h40400000;
      for (int i = 0; i < 5; i++) begin
         run_op(vin[i], res, lat, t_acc, to);
         n_tests++;
         if (to || res !== vexp[i]) begin
            n_fail++;
            $display("FAIL directed[%0d] in=%h: got %h expected %h timeout=%0d", i, vin[i], res, vexp[i], to);
         end
         n_tests++;
         if (lat !== LAT) begin
            n_fail++;
            $display("FAIL latency[%0d]: got %0d expected %0d", i, lat, LAT);
         end
      end
   endtask

   task automatic test_sign();
      logic [31:0] vin [6];
      logic [31:0] vexp [6];
      logic [31:0] res;
      int lat, t_acc, cnt;
      bit to;
`ifdef FSQRT_SPECIAL_EN
      cnt = 6;
      vin[0] = 32'hBF800000; vexp[0] = 32'h7FC00000;
      vin[1] = 32'h80000000; vexp[1] = 32'h80000000;
      vin[2] = 32'h7F800000; vexp[2] = 32'h7F800000;
      vin[3] = 32'h00000001; vexp[3] = 32'h00000000;
      vin[4] = 32'h7FA00001; vexp[4] = 32'h7FC00000;
      vin[5] = 32'hFF800000; vexp[5] = 32'h7FC00000;
`else
      cnt = 2;
      vin[0] = 32'hBF800000; vexp[0] = 32'h7F800001;
      vin[1] = 32'hC2C80000; vexp[1] = 32'h7F800001;
      for (int i = 2; i < 6; i++) begin vin[i] = 32'h0; vexp[i] = 32'h0; end
`endif
      for (int i = 0; i < cnt; i++) begin
         run_op(vin[i], res, lat, t_acc, to);
         n_tests++;
         if (to || res !== vexp[i] || lat !== LAT) begin
            n_fail++;
            $display("FAIL special[%0d] in=%h: got %h lat=%0d expected %h lat=%0d", i, vin[i], res, lat, vexp[i], LAT);
         end
      end
   endtask

   task automatic test_random();
      logic [31:0] d, res, rv;
      int lat, t_acc, diff;
      bit to;
      for (int i = 0; i < 10000; i++) begin
         d = {1'b0, 8'($urandom_range(1, 254)), 23'($urandom)};
         run_op(d, res, lat, t_acc, to);
         rv   = real_to_f32($sqrt(f32_to_real(d)));
         diff = int'(res) - int'(rv);
         n_tests++;
         if (to || diff > 1 || diff < -1) begin
            n_fail++;
            $display("FAIL random in=%h: got %h expected %h (+-1 ulp) timeout=%0d", d, res, rv, to);
         end
      end
   endtask

   task automatic test_squares();
      logic [31:0] d, res, rv;
      int lat, t_acc, k, p;
      bit to;
      for (int i = 0; i < 200; i++) begin
         k  = int'($urandom_range(1, 4095));
         p  = int'($urandom_range(0, 40)) - 20;
         d  = real_to_f32(real'(k) * real'(k) * pow2(2 * p));
         rv = real_to_f32(real'(k) * pow2(p));
         run_op(d, res, lat, t_acc, to);
         n_tests++;
         if (to || res !== rv) begin
            n_fail++;
            $display("FAIL square in=%h: got %h expected %h", d, res, rv);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] res;
      int lat, t0, t1;
      bit to0, to1;
      run_op(32'h40800000, res, lat, t0, to0);
      run_op(32'h41100000, res, lat, t1, to1);
      n_tests++;
      if (to0 || to1 || (t1 - t0) !== PERIOD) begin
         n_fail++;
         $display("FAIL throughput: got %0d cycles expected %0d", t1 - t0, PERIOD);
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] held;
      int n;
      bit seen;
      @(negedge clk);
      in_data   = 32'h40000000;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 50) begin @(negedge clk); n++; end
      held = out_data;
      n_tests++;
      if (out_valid !== 1'b1 || held !== 32'h3FB504F3) begin
         n_fail++;
         $display("FAIL bp_result: got vld=%b data=%h expected vld=1 data=3fb504f3", out_valid, held);
      end
      for (int i = 0; i < 20; i++) begin
         in_valid = 1'b1;
         in_data  = 32'h40800000;
         @(negedge clk);
         n_tests++;
         if (out_valid !== 1'b1 || out_data !== held || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_hold[%0d]: got vld=%b data=%h rdy=%b expected vld=1 data=%h rdy=0",
                     i, out_valid, out_data, in_ready, held);
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      n_tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_release: got vld=%b rdy=%b expected vld=0 rdy=1", out_valid, in_ready);
      end
      seen = 1'b0;
      repeat (12) begin @(negedge clk); if (out_valid) seen = 1'b1; end
      n_tests++;
      if (seen !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_ignored_input: got out_valid=1 expected 0");
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] res;
      int lat, t_acc;
      bit to, seen;
      @(negedge clk);
      in_data   = 32'h40000000;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      rstn = 1'b0;
      #1;
      n_tests++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_mid: got rdy=%b vld=%b data=%h expected rdy=1 vld=0 data=00000000",
                  in_ready, out_valid, out_data);
      end
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      seen = 1'b0;
      repeat (12) begin @(negedge clk); if (out_valid) seen = 1'b1; end
      n_tests++;
      if (seen !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_stale_valid: got out_valid=1 expected 0");
      end
      run_op(32'h3E800000, res, lat, t_acc, to);
      n_tests++;
      if (to || res !== 32'h3F000000) begin
         n_fail++;
         $display("FAIL reset_recover: got %h expected 3f000000", res);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_sign();
      test_back_to_back();
      test_backpressure();
      test_reset_mid();
      test_squares();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
